uart_rx_ctrl: RTL

- Receive-side controller between the UART receiver and the CPU/peripheral bus.
- Turns the receiver's level-type `done`/`rxdata` outputs into single byte captures and buffers them in a first-word-fall-through FIFO.
- Presents a valid/ready read port, and raises an interrupt on FIFO watermark, line-idle timeout or overrun.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_ctrl_sync_fifo.sv | 62 ++++++
 rtl/uart_rx_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default buffering constants and the
// receive-controller state encoding.
package uart_pkg;

  localparam int UART_DATA_W         = 8;
  localparam int UART_FIFO_DEPTH     = 16;
  localparam int UART_WATERMARK      = 8;
  localparam int UART_TIMEOUT_CYCLES = 4000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    TIMED_OUT = 2'd2
  } rx_ctrl_state_t;

endpackage

// File: rtl/uart_rx_ctrl_sync_fifo.sv
// First-word-fall-through FIFO (module sync_fifo). The head entry is presented
// on rdata whenever the FIFO is non-empty, and reads 0 when empty.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_DATA_W,
  parameter int DEPTH = UART_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_level == '0);
  assign full   = (r_level == LW'(DEPTH));
  assign w_pop  = pop & ~empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign rdata = empty ? '0 : r_mem[r_rd_ptr];
  assign level = r_level;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: edge-captures receiver bytes into a FWFT FIFO and
// raises irq on watermark, idle timeout or overrun. Optional macro
// UART_RX_CTRL_SYNC_EN adds a 2-flop input synchronizer.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH          = UART_FIFO_DEPTH,
  parameter int WATERMARK      = UART_WATERMARK,
  parameter int TIMEOUT_CYCLES = UART_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     rx_done,
  input  logic [UART_DATA_W-1:0]   rx_data,
  input  logic                     flush,
  input  logic                     clr_overrun,
  output logic                     rd_valid,
  output logic [UART_DATA_W-1:0]   rd_data,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     timeout,
  output logic                     overrun,
  output logic                     irq
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [LVL_W-1:0] WM_LVL   = LVL_W'(WATERMARK);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic                   w_done;
  logic [UART_DATA_W-1:0] w_data;
  logic                   r_done_q;
  logic                   w_cap;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_fifo_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [LVL_W-1:0]       w_level;
  logic [LVL_W-1:0]       w_level_nxt;
  logic [UART_DATA_W-1:0] w_rdata;
  logic                   w_drop_ovr;
  logic                   w_ovr_nxt;
  logic                   r_overrun;
  logic                   r_irq;
  logic                   w_irq_nxt;
  rx_ctrl_state_t         r_state;
  rx_ctrl_state_t         w_state_nxt;
  logic [TMR_W-1:0]       r_timer;
  logic [TMR_W-1:0]       w_timer_nxt;
  logic [TMR_W-1:0]       w_timer_inc;

`ifdef UART_RX_CTRL_SYNC_EN
  logic                   r_done_p1;
  logic                   r_done_p2;
  logic [UART_DATA_W-1:0] r_data_p1;
  logic [UART_DATA_W-1:0] r_data_p2;

  // Synchronizer stage p1 -> p2; data rides alongside done so it is stable at capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done_p1 <= 1'b0;
      r_done_p2 <= 1'b0;
    end else begin
      r_done_p1 <= rx_done;
      r_done_p2 <= r_done_p1;
    end
  end

  always_ff @(posedge clk) begin
    r_data_p1 <= rx_data;
    r_data_p2 <= r_data_p1;
  end

  assign w_done = r_done_p2;
  assign w_data = r_data_p2;
`else
  assign w_done = rx_done;
  assign w_data = rx_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_done_q <= 1'b0;
    else     r_done_q <= w_done;
  end

  assign w_cap      = w_done & ~r_done_q & enable;
  assign rd_valid   = ~w_empty;
  assign w_pop      = rd_valid & rd_ready;
  // Flush wins over any same-cycle capture or pop.
  assign w_push     = w_cap & (~w_full | w_pop) & ~flush;
  assign w_fifo_pop = w_pop & ~flush;
  assign w_drop_ovr = w_cap & w_full & ~w_pop & ~flush;

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (w_push),
    .pop   (w_fifo_pop),
    .wdata (w_data),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  always_comb begin
    w_level_nxt = w_level;
    if (flush)                      w_level_nxt = '0;
    else if (w_push && !w_fifo_pop) w_level_nxt = w_level + LVL_W'(1);
    else if (!w_push && w_fifo_pop) w_level_nxt = w_level - LVL_W'(1);
  end

  // A same-cycle set beats the clear.
  assign w_ovr_nxt   = w_drop_ovr | (r_overrun & ~clr_overrun);
  assign w_timer_inc = r_timer + TMR_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    case (r_state)
      IDLE: begin
        w_timer_nxt = '0;
        if (w_push) w_state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (flush || w_level_nxt == '0) begin
          w_state_nxt = IDLE;
          w_timer_nxt = '0;
        end else if (w_cap) begin
          w_timer_nxt = '0;
        end else if (w_timer_inc >= TMR_LAST) begin
          w_state_nxt = TIMED_OUT;
          w_timer_nxt = TMR_LAST;
        end else begin
          w_timer_nxt = w_timer_inc;
        end
      end
      TIMED_OUT: begin
        if (flush || w_level_nxt == '0) begin
          w_state_nxt = IDLE;
          w_timer_nxt = '0;
        end else if (w_pop || w_cap) begin
          w_state_nxt = ACTIVE;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = TMR_LAST;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  // irq is computed from next-state values so it lines up with the flags.
  assign w_irq_nxt = (w_level_nxt >= WM_LVL) | (w_state_nxt == TIMED_OUT) | w_ovr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_overrun <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_overrun <= w_ovr_nxt;
      r_irq     <= w_irq_nxt;
    end
  end

  assign rd_data = w_rdata;
  assign level   = w_level;
  assign timeout = (r_state == TIMED_OUT);
  assign overrun = r_overrun;
  assign irq     = r_irq;

endmodule
